jtag_tap_multichain: RTL and testbench

JTAG_TAP_MULTICHAIN -- requirements
Module: jtag_tap_multichain

---
 rtl/jtag_pkg.sv | 28 ++
 rtl/jtag_tap_fsm.sv | 50 +++++
 rtl/jtag_tap_multichain.sv | 141 ++++++++++++++
 tb/tb_jtag_tap_multichain.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings and fixed instruction values.
// Imported by the TAP FSM and the multichain TAP top.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EX2_DR  = 4'h0,
        TAP_EX1_DR  = 4'h1,
        TAP_SH_DR   = 4'h2,
        TAP_PAU_DR  = 4'h3,
        TAP_SEL_IR  = 4'h4,
        TAP_UPD_DR  = 4'h5,
        TAP_CAP_DR  = 4'h6,
        TAP_SEL_DR  = 4'h7,
        TAP_EX2_IR  = 4'h8,
        TAP_EX1_IR  = 4'h9,
        TAP_SH_IR   = 4'hA,
        TAP_PAU_IR  = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPD_IR  = 4'hD,
        TAP_CAP_IR  = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_t;

    // Instruction constants are wide enough for any IR; users slice [IR_WIDTH-1:0].
    localparam logic [15:0] INSTR_IDCODE = 16'h0000;
    localparam logic [15:0] INSTR_BYPASS = 16'hFFFF;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller, advanced by tms_i on each rising tck_i.
// Synchronous active-low reset forces Test-Logic-Reset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_n_i,
    input  logic       tms_i,
    output tap_state_t state_o
);

    tap_state_t state_r;
    tap_state_t state_next_s;

    // State register with synchronous reset to TLR.
    always_ff @(posedge tck_i) begin
        if (!trst_n_i) begin
            state_r <= TAP_TLR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode of the standard TAP graph.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            TAP_TLR:    state_next_s = tms_i ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    state_next_s = tms_i ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: state_next_s = tms_i ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: state_next_s = tms_i ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  state_next_s = tms_i ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: state_next_s = tms_i ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: state_next_s = tms_i ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: state_next_s = tms_i ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: state_next_s = tms_i ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: state_next_s = tms_i ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: state_next_s = tms_i ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  state_next_s = tms_i ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: state_next_s = tms_i ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: state_next_s = tms_i ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: state_next_s = tms_i ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: state_next_s = tms_i ? TAP_SEL_DR : TAP_RTI;
            default:    state_next_s = TAP_TLR;
        endcase
    end

    assign state_o = state_r;

endmodule

// File: rtl/jtag_tap_multichain.sv
// JTAG TAP with IDCODE, BYPASS and CHAIN_NUM external scan chains selected by instruction.
// Chains shift themselves from tdi_i; this block only forwards their serial output.
module jtag_tap_multichain
    import jtag_pkg::*;
#(
    parameter int          CHAIN_NUM = 2,
    parameter int          IR_WIDTH  = 4,
    parameter logic [31:0] IDCODE    = 32'h1000_0001
) (
    input  logic                 tck_i,
    input  logic                 trst_n_i,
    input  logic                 tms_i,
    input  logic                 tdi_i,
    input  logic [CHAIN_NUM-1:0] chain_tdo_i,
    output logic                 tdo_o,
    output logic [3:0]           tap_state_o,
    output logic [IR_WIDTH-1:0]  instr_o,
    output logic [CHAIN_NUM-1:0] chain_sel_o,
    output logic                 capture_dr_o,
    output logic                 shift_dr_o,
    output logic                 update_dr_o
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = INSTR_IDCODE[IR_WIDTH-1:0];

    tap_state_t            state_s;
    logic [IR_WIDTH-1:0]   ir_shift_r;
    logic [IR_WIDTH-1:0]   instr_r;
    logic [31:0]           id_r;
    logic                  bypass_r;
    logic                  tdo_r;
    logic [CHAIN_NUM-1:0]  chain_sel_s;
    logic                  chain_bit_s;
    logic                  is_chain_s;
    logic                  is_idcode_s;
    logic                  dr_out_s;
    logic                  tdo_next_s;

    jtag_tap_fsm u_fsm (
        .tck_i    (tck_i),
        .trst_n_i (trst_n_i),
        .tms_i    (tms_i),
        .state_o  (state_s)
    );

    // Instruction decode: one-hot chain select and forwarded chain output.
    always_comb begin
        chain_sel_s = '0;
        chain_bit_s = 1'b0;
        for (int k = 0; k < CHAIN_NUM; k++) begin
            chain_sel_s[k] = (instr_r == IR_WIDTH'(k + 1));
            chain_bit_s    = chain_bit_s | (chain_sel_s[k] & chain_tdo_i[k]);
        end
        is_chain_s  = |chain_sel_s;
        is_idcode_s = (instr_r == IR_IDCODE);
    end

    // Outgoing serial bit for the current shift state; zero outside shifting.
    always_comb begin
        dr_out_s   = 1'b0;
        tdo_next_s = 1'b0;
        if (is_chain_s) begin
            dr_out_s = chain_bit_s;
        end else if (is_idcode_s) begin
            dr_out_s = id_r[0];
        end else begin
            dr_out_s = bypass_r;
        end
        if (state_s == TAP_SH_IR) begin
            tdo_next_s = ir_shift_r[0];
        end else if (state_s == TAP_SH_DR) begin
            tdo_next_s = dr_out_s;
        end else begin
            tdo_next_s = 1'b0;
        end
    end

    // IR shift register, active instruction and serial output register.
    always_ff @(posedge tck_i) begin
        if (!trst_n_i) begin
            ir_shift_r <= '0;
            instr_r    <= '0;
            tdo_r      <= 1'b0;
        end else begin
            tdo_r <= tdo_next_s;
            case (state_s)
                TAP_TLR:    instr_r    <= IR_IDCODE;
                TAP_UPD_IR: instr_r    <= ir_shift_r;
                TAP_CAP_IR: ir_shift_r <= IR_CAPTURE;
                TAP_SH_IR:  ir_shift_r <= {tdi_i, ir_shift_r[IR_WIDTH-1:1]};
                default: begin
                    ir_shift_r <= ir_shift_r;
                    instr_r    <= instr_r;
                end
            endcase
        end
    end

    // Internal data registers; chain instructions leave both untouched.
    always_ff @(posedge tck_i) begin
        if (!trst_n_i) begin
            id_r     <= IDCODE;
            bypass_r <= 1'b0;
        end else begin
            case (state_s)
                TAP_CAP_DR: begin
                    if (is_idcode_s) begin
                        id_r <= IDCODE;
                    end else if (!is_chain_s) begin
                        bypass_r <= 1'b0;
                    end else begin
                        id_r <= id_r;
                    end
                end
                TAP_SH_DR: begin
                    if (is_idcode_s) begin
                        id_r <= {tdi_i, id_r[31:1]};
                    end else if (!is_chain_s) begin
                        bypass_r <= tdi_i;
                    end else begin
                        id_r <= id_r;
                    end
                end
                default: begin
                    id_r     <= id_r;
                    bypass_r <= bypass_r;
                end
            endcase
        end
    end

    assign tdo_o        = tdo_r;
    assign tap_state_o  = state_s;
    assign instr_o      = instr_r;
    assign chain_sel_o  = chain_sel_s;
    assign capture_dr_o = (state_s == TAP_CAP_DR) && is_chain_s;
    assign shift_dr_o   = (state_s == TAP_SH_DR)  && is_chain_s;
    assign update_dr_o  = (state_s == TAP_UPD_DR) && is_chain_s;

endmodule

// File: tb/tb_jtag_tap_multichain.sv
// Directed bench for jtag_tap_multichain: stimulus pushes expected values into a
// scoreboard queue tagged with the edge count; a monitor pops and compares on negedge.
module tb_jtag_tap_multichain;

    localparam int CHAIN_NUM = 2;
    localparam int IR_WIDTH  = 4;
    localparam logic [31:0] IDC = 32'h1000_0001;

    localparam int K_TDO   = 0;
    localparam int K_STATE = 1;
    localparam int K_INSTR = 2;
    localparam int K_SEL   = 3;
    localparam int K_CAP   = 4;
    localparam int K_SHIFT = 5;
    localparam int K_UPD   = 6;

    logic                 tck_i = 1'b0;
    logic                 trst_n_i = 1'b0;
    logic                 tms_i = 1'b1;
    logic                 tdi_i = 1'b0;
    logic [CHAIN_NUM-1:0] chain_tdo_i = '0;
    logic                 tdo_o;
    logic [3:0]           tap_state_o;
    logic [IR_WIDTH-1:0]  instr_o;
    logic [CHAIN_NUM-1:0] chain_sel_o;
    logic                 capture_dr_o;
    logic                 shift_dr_o;
    logic                 update_dr_o;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    jtag_tap_multichain #(
        .CHAIN_NUM (CHAIN_NUM),
        .IR_WIDTH  (IR_WIDTH),
        .IDCODE    (IDC)
    ) dut (
        .tck_i        (tck_i),
        .trst_n_i     (trst_n_i),
        .tms_i        (tms_i),
        .tdi_i        (tdi_i),
        .chain_tdo_i  (chain_tdo_i),
        .tdo_o        (tdo_o),
        .tap_state_o  (tap_state_o),
        .instr_o      (instr_o),
        .chain_sel_o  (chain_sel_o),
        .capture_dr_o (capture_dr_o),
        .shift_dr_o   (shift_dr_o),
        .update_dr_o  (update_dr_o)
    );

    always #5 tck_i = ~tck_i;

    always @(posedge tck_i) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_TDO:   return {31'd0, tdo_o};
            K_STATE: return {28'd0, tap_state_o};
            K_INSTR: return {28'd0, instr_o};
            K_SEL:   return {30'd0, chain_sel_o};
            K_CAP:   return {31'd0, capture_dr_o};
            K_SHIFT: return {31'd0, shift_dr_o};
            K_UPD:   return {31'd0, update_dr_o};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation due by this edge.
    always @(negedge tck_i) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            act = observe(e.kind);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s (edge %0d): got %h expected %h", e.name, e.cyc, act, e.exp);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge tck_i);
        #1;
    endtask

    // From RTI: shift an instruction LSB first, update, return to RTI.
    task automatic load_ir(input logic [3:0] v);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        expect_v(K_INSTR, {28'd0, v}, "instr_load");
        expect_v(K_STATE, 32'hC, "state_rti_after_ir");
    endtask

    // From RTI into Shift-DR (after the Capture-DR edge).
    task automatic enter_shdr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        logic [4:0] bp_tdi;
        logic [4:0] bp_tdo;

        // Reset state
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        expect_v(K_STATE, 32'hF, "rst_state");
        expect_v(K_INSTR, 32'h0, "rst_instr");
        expect_v(K_TDO,   32'h0, "rst_tdo");
        expect_v(K_SEL,   32'h0, "rst_sel");
        trst_n_i = 1'b1;
        tick(1'b1, 1'b0);
        expect_v(K_STATE, 32'hF, "tlr_hold");

        // IDCODE read from TLR: tms 0,1,0,0 then 32 shift edges
        tick(1'b0, 1'b0);
        expect_v(K_STATE, 32'hC, "state_rti");
        tick(1'b1, 1'b0);
        expect_v(K_STATE, 32'h7, "state_seldr");
        tick(1'b0, 1'b0);
        expect_v(K_STATE, 32'h6, "state_capdr");
        expect_v(K_CAP,   32'h0, "cap_strobe_idcode");
        tick(1'b0, 1'b0);
        expect_v(K_STATE, 32'h2, "state_shdr");
        for (int i = 0; i < 32; i++) begin
            tick(i == 31, 1'b0);
            expect_v(K_TDO, {31'd0, IDC[i]}, "idcode_bit");
        end
        expect_v(K_STATE, 32'h1, "state_ex1dr");
        tick(1'b1, 1'b0);
        expect_v(K_TDO,   32'h0, "tdo_zero_ex1");
        expect_v(K_STATE, 32'h5, "state_upddr");
        tick(1'b0, 1'b0);

        // IR shift of 1111: tdo shows captured 0001
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        expect_v(K_STATE, 32'h4, "state_selir");
        tick(1'b0, 1'b0);
        expect_v(K_STATE, 32'hE, "state_capir");
        tick(1'b0, 1'b0);
        expect_v(K_STATE, 32'hA, "state_shir");
        pat = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, 1'b1);
            expect_v(K_TDO, {31'd0, pat[i]}, "ir_capture_bit");
        end
        expect_v(K_INSTR, 32'h0, "instr_stable_in_shir");
        tick(1'b1, 1'b0);
        expect_v(K_STATE, 32'hD, "state_updir");
        expect_v(K_INSTR, 32'h0, "instr_before_upd_edge");
        tick(1'b0, 1'b0);
        expect_v(K_INSTR, 32'hF, "instr_bypass");

        // BYPASS: tdi 1,0,1,1,0 -> tdo 0,1,0,1,1
        enter_shdr();
        bp_tdi = 5'b01101;
        bp_tdo = 5'b11010;
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, bp_tdi[i]);
            expect_v(K_TDO, {31'd0, bp_tdo[i]}, "bypass_bit");
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // Chain 1 selected: strobes and forwarded tdo
        load_ir(4'h2);
        expect_v(K_SEL, 32'h2, "sel_chain1");
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        expect_v(K_CAP, 32'h1, "cap_strobe_chain");
        tick(1'b0, 1'b0);
        expect_v(K_SHIFT, 32'h1, "shift_strobe_chain");
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            chain_tdo_i = {pat[i], ~pat[i]};
            tick(i == 3, 1'b0);
            expect_v(K_TDO, {31'd0, pat[i]}, "chain1_bit");
        end
        expect_v(K_SHIFT, 32'h0, "shift_strobe_off");
        tick(1'b1, 1'b0);
        expect_v(K_UPD, 32'h1, "upd_strobe_chain");
        tick(1'b0, 1'b0);
        expect_v(K_UPD, 32'h0, "upd_strobe_off");
        load_ir(4'h1);
        expect_v(K_SEL, 32'h1, "sel_chain0");

        // Unused code 5: no select, strobes low, behaves as bypass incl. pause hold
        load_ir(4'h5);
        expect_v(K_SEL, 32'h0, "sel_none_5");
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        expect_v(K_CAP, 32'h0, "cap_strobe_5");
        tick(1'b0, 1'b0);
        expect_v(K_SHIFT, 32'h0, "shift_strobe_5");
        chain_tdo_i = 2'b11;
        bp_tdi = 5'b01011;
        bp_tdo = 5'b00110;
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, bp_tdi[i]);
            expect_v(K_TDO, {31'd0, bp_tdo[i]}, "bypass5_bit");
        end
        tick(1'b0, 1'b0);
        expect_v(K_STATE, 32'h3, "state_paudr");
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        expect_v(K_STATE, 32'h0, "state_ex2dr");
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        expect_v(K_TDO, 32'h1, "bypass_pause_hold");
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // Reset in the middle of a chain shift
        load_ir(4'h2);
        enter_shdr();
        chain_tdo_i = 2'b10;
        tick(1'b0, 1'b0);
        expect_v(K_TDO, 32'h1, "chain_tdo_pre_rst");
        trst_n_i = 1'b0;
        tick(1'b0, 1'b1);
        expect_v(K_STATE, 32'hF, "midshift_rst_state");
        expect_v(K_INSTR, 32'h0, "midshift_rst_instr");
        expect_v(K_TDO,   32'h0, "midshift_rst_tdo");
        expect_v(K_SEL,   32'h0, "midshift_rst_sel");
        expect_v(K_SHIFT, 32'h0, "midshift_rst_shift");
        trst_n_i = 1'b1;
        chain_tdo_i = 2'b00;

        // From Pause-IR, five tms=1 edges reach TLR
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        expect_v(K_STATE, 32'h9, "state_ex1ir");
        tick(1'b0, 1'b0);
        expect_v(K_STATE, 32'hB, "state_pauir");
        tick(1'b1, 1'b0);
        expect_v(K_STATE, 32'h8, "state_ex2ir");
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        expect_v(K_STATE, 32'hF, "pauir_to_tlr");

        repeat (3) @(posedge tck_i);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
